mul_share_arbiter: RTL and testbench



---
 rtl/mul_share_pkg.sv | 13 +
 rtl/multiplier.sv | 10 +
 rtl/mul_share_arbiter.sv | 137 +++++++++++++
 tb/tb_mul_share_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
package mul_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

endpackage

// File: rtl/multiplier.sv
// 4x4 unsigned combinational multiplier shared by the arbiter cluster.
module multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product
);

    assign product = {4'b0000, a} * {4'b0000, b};

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin front end that time-shares one multiplier among NREQ requesters.
// Handshakes: a transfer happens on a rising edge where valid && ready; req_* and resp_* hold until then.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [OP_W*NREQ-1:0]   req_a,
    input  logic [OP_W*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]        req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [PROD_W-1:0]      resp_product,
    output logic                   busy,
    output state_e                 state_o
);

    state_e              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [OP_W-1:0]     op_a_q, op_a_d;
    logic [OP_W-1:0]     op_b_q, op_b_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [PROD_W-1:0]   mult_out;

    logic [OP_W-1:0]     a_arr [NREQ];
    logic [OP_W-1:0]     b_arr [NREQ];
    logic                grant_valid;
    logic [IDW-1:0]      grant_idx;
    logic [NREQ-1:0]     grant_oh;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        if (v == IDW'(NREQ - 1)) begin
            return '0;
        end
        return v + IDW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = req_a[i*OP_W +: OP_W];
            b_arr[i] = req_b[i*OP_W +: OP_W];
        end
    end

    // First valid requester at or after rr_ptr_q, wrapping modulo NREQ.
    always_comb begin
        logic [IDW-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        idx         = rr_ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_valid && req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
            idx = wrap_inc(idx);
        end
        for (int i = 0; i < NREQ; i++) begin
            grant_oh[i] = grant_valid && (grant_idx == IDW'(i));
        end
    end

    multiplier u_mult (
        .a       (op_a_q),
        .b       (op_b_q),
        .product (mult_out)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        prod_d    = prod_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                // A grant raised while rst is high would be thrown away, so hide it.
                if (!rst) begin
                    req_ready = grant_oh;
                end
                if (grant_valid) begin
                    op_a_d   = a_arr[grant_idx];
                    op_b_d   = b_arr[grant_idx];
                    id_d     = grant_idx;
                    rr_ptr_d = wrap_inc(grant_idx);
                    state_d  = CALC;
                end
            end
            CALC: begin
                prod_d  = mult_out;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            prod_q   <= prod_d;
        end
    end

    assign resp_valid   = (state_q == RESP);
    assign busy         = (state_q != IDLE);
    assign resp_id      = id_q;
    assign resp_product = prod_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter: directed vectors, corner sequences and a randomized run
// against a transaction-level round-robin model.
module tb_mul_share_arbiter;
    import mul_share_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int SB_W = IDW + PROD_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [OP_W*NREQ-1:0] req_a;
    logic [OP_W*NREQ-1:0] req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [IDW-1:0]       resp_id;
    logic [PROD_W-1:0]    resp_product;
    logic                 busy;
    state_e               state_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [SB_W-1:0] exp_q[$];

    typedef struct {
        logic [NREQ-1:0]      valid;
        logic [OP_W*NREQ-1:0] a_bus;
        logic [OP_W*NREQ-1:0] b_bus;
        int                   exp_id;
        int                   exp_prod;
    } vec_t;
    vec_t vecs[5];

    // transaction-level model state for the randomized run
    int  m_ptr;
    bit  m_pend;
    bit  m_in_resp;
    int  m_grant;
    int  wait_cnt[NREQ];
    logic [NREQ-1:0]   exp_ready;
    logic [SB_W-1:0]   exp_word;

    mul_share_arbiter #(.NREQ(NREQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .busy         (busy),
        .state_o      (state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 4'b0110;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        to_neg();
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_product", resp_product, 0);
        check("rst_state", state_o, IDLE);
        req_valid = '0;
        rst       = 1'b0;
        tick();
    endtask

    // Called in the post-edge phase with the DUT idle and resp_ready high.
    task automatic serve_one(input int id, input int prod);
        to_neg();
        check("grant_req_ready", req_ready, 1 << id);
        check("grant_busy", busy, 0);
        check("grant_resp_valid", resp_valid, 0);
        tick();
        req_valid[id] = 1'b0;
        to_neg();
        check("calc_busy", busy, 1);
        check("calc_resp_valid", resp_valid, 0);
        check("calc_req_ready", req_ready, 0);
        tick();
        to_neg();
        check("resp_valid", resp_valid, 1);
        check("resp_id", resp_id, id);
        check("resp_product", resp_product, prod);
        tick();
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    initial begin : main
        vecs[0] = '{4'b0100, 16'h0D00, 16'h0B00, 2, 143};
        vecs[1] = '{4'b1010, 16'h9060, 16'h9070, 1, 42};
        vecs[2] = '{4'b1000, 16'hF000, 16'hF000, 3, 225};
        vecs[3] = '{4'b0001, 16'h0000, 16'h0005, 0, 0};
        vecs[4] = '{4'b1111, 16'h0002, 16'h0003, 0, 6};

        // table-driven single grants from a fresh pointer
        for (int v = 0; v < 5; v++) begin
            do_reset();
            resp_ready = 1'b1;
            req_valid  = vecs[v].valid;
            req_a      = vecs[v].a_bus;
            req_b      = vecs[v].b_bus;
            serve_one(vecs[v].exp_id, vecs[v].exp_prod);
            req_valid  = '0;
        end

        // all four contend, grants 3 cycles apart
        do_reset();
        resp_ready = 1'b1;
        req_valid  = 4'b1111;
        req_a      = 16'h70F3;
        req_b      = 16'h89F5;
        serve_one(0, 15);
        serve_one(1, 225);
        serve_one(2, 0);
        serve_one(3, 56);

        // pointer wrap: after serving req1, req0 goes before req1
        do_reset();
        resp_ready = 1'b1;
        req_valid  = 4'b0010;
        req_a      = 16'h0030;
        req_b      = 16'h0040;
        serve_one(1, 12);
        req_valid  = 4'b0011;
        req_a      = 16'h0095;
        req_b      = 16'h00A2;
        serve_one(0, 10);
        serve_one(1, 90);

        // backpressure: response held for 5 cycles, other requests stay blocked
        do_reset();
        req_valid = 4'b0100;
        req_a     = 16'h0D00;
        req_b     = 16'h0B00;
        to_neg();
        check("bp_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        req_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            to_neg();
            check("bp_resp_valid", resp_valid, 1);
            check("bp_resp_id", resp_id, 2);
            check("bp_resp_product", resp_product, 143);
            check("bp_req_ready", req_ready, 0);
            tick();
        end
        resp_ready = 1'b1;
        to_neg();
        check("bp_release_valid", resp_valid, 1);
        tick();
        to_neg();
        check("bp_after_valid", resp_valid, 0);
        check("bp_next_grant", req_ready, 4'b1000);
        tick();
        req_valid = '0;

        // reset during CALC discards the operation and restarts the pointer
        do_reset();
        resp_ready = 1'b1;
        req_valid  = 4'b0100;
        req_a      = 16'h0500;
        req_b      = 16'h0300;
        to_neg();
        check("rc_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        rst       = 1'b1;
        to_neg();
        check("rc_calc_busy", busy, 1);
        tick();
        rst       = 1'b0;
        req_valid = 4'b1001;
        req_a     = 16'h2004;
        req_b     = 16'h3005;
        serve_one(0, 20);
        serve_one(3, 6);

        // exhaustive datapath through requester 1
        do_reset();
        resp_ready = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                req_valid = 4'b0010;
                req_a     = {8'h00, 4'(a), 4'h0};
                req_b     = {8'h00, 4'(b), 4'h0};
                serve_one(1, a * b);
            end
        end

        // randomized traffic against the transaction-level model
        do_reset();
        m_ptr     = 0;
        m_pend    = 1'b0;
        m_in_resp = 1'b0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid[i]          = 1'b1;
                        req_a[i*OP_W +: OP_W] = 4'($urandom_range(0, 15));
                        req_b[i*OP_W +: OP_W] = 4'($urandom_range(0, 15));
                        wait_cnt[i]           = 0;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 2) != 0);
            m_grant    = m_pend ? -1 : rr_pick(req_valid, m_ptr);
            exp_ready  = (m_grant >= 0) ? NREQ'(1 << m_grant) : '0;

            to_neg();
            check("rnd_req_ready", req_ready, exp_ready);
            check("rnd_busy", busy, m_pend);
            check("rnd_resp_valid", resp_valid, m_pend && m_in_resp);
            if (m_pend && m_in_resp && resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rnd_resp_data: actual=%0d required=none (scoreboard empty)",
                             {resp_id, resp_product});
                end else begin
                    check("rnd_resp_data", {resp_id, resp_product}, exp_q[0]);
                end
            end
            tick();

            if (m_grant >= 0) begin
                check("rnd_fairness", wait_cnt[m_grant] < NREQ, 1);
                for (int i = 0; i < NREQ; i++) begin
                    if (i != m_grant && req_valid[i]) wait_cnt[i]++;
                end
                exp_word = {IDW'(m_grant),
                            PROD_W'(int'(req_a[m_grant*OP_W +: OP_W]) * int'(req_b[m_grant*OP_W +: OP_W]))};
                exp_q.push_back(exp_word);
                req_valid[m_grant] = 1'b0;
                wait_cnt[m_grant]  = 0;
                m_pend             = 1'b1;
                m_in_resp          = 1'b0;
                m_ptr              = (m_grant + 1) % NREQ;
            end else if (m_pend) begin
                if (!m_in_resp) begin
                    m_in_resp = 1'b1;
                end else if (resp_ready) begin
                    m_pend = 1'b0;
                    void'(exp_q.pop_front());
                end
            end
        end

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
